// File: rtl/nco_meas_pkg.sv
// Shared constants, state encoding and helpers for the NCO divider and its period meter.
package nco_meas_pkg;

    localparam int unsigned CLK_IN_FREQ_DEF  = 50_000_000;
    localparam int unsigned MIN_SIG_FREQ_DEF = 1_000;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        MEASURE_FIRST = 2'd1,
        MEASURE       = 2'd2
    } meas_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned     width;
        longint unsigned span;
        width = 0;
        span  = 64'd1;
        while (span < 64'(value)) begin
            span  = span << 1;
            width += 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, plus a previous-level register
// so that single-cycle rise/fall pulses come out in the clk_i domain.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign s_o    = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles.
//   IDLE          | waiting for a first rising edge, cnt held at 0
//   MEASURE_FIRST | first interval open; it is discarded when the next rise closes it
//   MEASURE       | each rise publishes period/high with a one-cycle meas_valid
module clock_period_meter
    import nco_meas_pkg::*;
#(
    parameter int unsigned CLK_IN_FREQ    = CLK_IN_FREQ_DEF,
    parameter int unsigned MIN_SIG_FREQ   = MIN_SIG_FREQ_DEF,
    parameter int unsigned TIMEOUT_CYCLES = CLK_IN_FREQ / MIN_SIG_FREQ,
    parameter int unsigned CNT_W          = clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] high_cycles,
    output logic             meas_valid,
    output logic             sig_lost
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    meas_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic             sig_level_unused;
    logic             rise;
    logic             fall;

    sync_edge_detect u_sync (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .sig_i  (sig_in),
        .s_o    (sig_level_unused),
        .rise_o (rise),
        .fall_o (fall)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        lost_d   = lost_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = MEASURE_FIRST;
                    cnt_d   = ONE_C;
                end
            end
            MEASURE_FIRST, MEASURE: begin
                cnt_d = cnt_q + ONE_C;
                if (fall) begin
                    hi_d = cnt_q;
                end
                // A rise landing exactly on the timeout count still closes a valid period.
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = ONE_C;
                    if (state_q == MEASURE) begin
                        period_d = cnt_q;
                        high_d   = hi_q;
                        valid_d  = 1'b1;
                        lost_d   = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    lost_d   = 1'b1;
                    period_d = '0;
                    high_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign period_cycles = period_q;
    assign high_cycles   = high_q;
    assign meas_valid    = valid_q;
    assign sig_lost      = lost_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: table-driven square waves, hand-written corner sequences,
// and a per-cycle comparison against an edge-timestamp reference model.
module tb_clock_period_meter;
    import nco_meas_pkg::*;

    localparam int TO = 40;
    localparam int W  = 6;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] period_cycles;
    logic [W-1:0] high_cycles;
    logic         meas_valid;
    logic         sig_lost;

    int n_checks = 0;
    int n_fail   = 0;

    clock_period_meter #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (W)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .sig_in        (sig_in),
        .period_cycles (period_cycles),
        .high_cycles   (high_cycles),
        .meas_valid    (meas_valid),
        .sig_lost      (sig_lost)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timestamps of sampled edges; outputs appear two edges after the sample.
    typedef struct {
        int v;
        int lost;
        int p;
        int h;
    } exp_t;

    exp_t pipe0, pipe1, expd;
    int   m_idx, m_nr, m_last_rise, m_last_fall, m_p, m_h, m_lost, m_v;
    bit   m_prev;

    initial begin
        forever begin
            @(posedge clk_in or posedge rst);
            if (rst) begin
                m_idx = 0; m_nr = 0; m_last_rise = 0; m_last_fall = 0;
                m_p = 0; m_h = 0; m_lost = 0; m_prev = 1'b0;
                pipe0 = '{0, 0, 0, 0};
                pipe1 = '{0, 0, 0, 0};
                expd  = '{0, 0, 0, 0};
            end else begin
                m_idx++;
                m_v = 0;
                if (m_nr >= 1 && !sig_in && m_prev) m_last_fall = m_idx;
                if (sig_in && !m_prev) begin
                    if (m_nr >= 2) begin
                        m_v = 1;
                        m_p = m_idx - m_last_rise;
                        m_h = m_last_fall - m_last_rise;
                        m_lost = 0;
                    end
                    m_nr = (m_nr >= 2) ? 2 : m_nr + 1;
                    m_last_rise = m_idx;
                end else if (m_nr >= 1 && (m_idx - m_last_rise) == TO) begin
                    m_nr = 0;
                    m_lost = 1;
                    m_p = 0;
                    m_h = 0;
                end
                m_prev = sig_in;
                expd  = pipe1;
                pipe1 = pipe0;
                pipe0 = '{m_v, m_lost, m_p, m_h};
            end
        end
    end

    int strobes   = 0;
    int last_p    = 0;
    int last_h    = 0;
    bit lost_seen = 1'b0;
    bit jit_on    = 1'b0;
    bit prev_mv   = 1'b0;
    int diff;

    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst) begin
                check("model_valid",  32'(meas_valid),    32'(expd.v));
                check("model_lost",   32'(sig_lost),      32'(expd.lost));
                check("model_period", 32'(period_cycles), 32'(expd.p));
                check("model_high",   32'(high_cycles),   32'(expd.h));
                check("valid_width",  32'(meas_valid && prev_mv), 32'(0));
                prev_mv = meas_valid;
                if (sig_lost) lost_seen = 1'b1;
                if (meas_valid) begin
                    strobes++;
                    last_p = int'(period_cycles);
                    last_h = int'(high_cycles);
                    if (jit_on) begin
                        diff = last_p - 13;
                        check("jitter_period_pm1", 32'(diff >= -1 && diff <= 1), 32'(1));
                    end
                end
            end else begin
                prev_mv = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sq(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            repeat (hi) @(negedge clk_in);
            sig_in = 1'b0;
            repeat (lo) @(negedge clk_in);
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int n;
        int exp_p;
        int exp_h;
    } vec_t;

    vec_t vecs[6];
    int   offs[8];
    int   off_r, off_f;

    initial begin
        vecs[0] = '{5, 5, 4, 10, 5};
        vecs[1] = '{3, 9, 4, 12, 3};
        vecs[2] = '{6, 6, 4, 12, 6};
        vecs[3] = '{20, 20, 3, 40, 20};
        vecs[4] = '{2, 2, 4, 4, 2};
        vecs[5] = '{39, 1, 3, 40, 39};
        offs    = '{1, 2, 3, 4, 6, 7, 8, 9};

        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_period", 32'(period_cycles), 32'(0));
        check("rst_high",   32'(high_cycles),   32'(0));
        check("rst_valid",  32'(meas_valid),    32'(0));
        check("rst_lost",   32'(sig_lost),      32'(0));
        check("rst_state",  32'(dut.state_q),   32'(IDLE));
        #2 rst = 1'b0;
        @(negedge clk_in);

        strobes = 0;
        sq(5, 5, 2);
        check("first_period_no_strobe", 32'(strobes), 32'(0));

        for (int v = 0; v < 6; v++) begin
            strobes = 0;
            lost_seen = 1'b0;
            sq(vecs[v].hi, vecs[v].lo, vecs[v].n);
            check($sformatf("vec%0d_period", v),  32'(last_p),    32'(vecs[v].exp_p));
            check($sformatf("vec%0d_high", v),    32'(last_h),    32'(vecs[v].exp_h));
            check($sformatf("vec%0d_strobes", v), 32'(strobes),   32'(vecs[v].n));
            check($sformatf("vec%0d_no_lost", v), 32'(lost_seen), 32'(0));
        end

        // Loss of signal: one last rise, then held low.
        sig_in = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            @(negedge clk_in);
            if (k == 3) sig_in = 1'b0;
            if (k == 42) check("lost_not_early", 32'(sig_lost), 32'(0));
            if (k == 43) begin
                check("lost_on_time",  32'(sig_lost),      32'(1));
                check("lost_period_0", 32'(period_cycles), 32'(0));
                check("lost_high_0",   32'(high_cycles),   32'(0));
            end
        end
        repeat (5) @(negedge clk_in);

        strobes = 0;
        sq(5, 5, 2);
        check("restart_no_strobe", 32'(strobes),  32'(0));
        check("restart_lost_held", 32'(sig_lost), 32'(1));
        sq(5, 5, 1);
        check("restart_strobe",  32'(strobes),  32'(1));
        check("restart_lost_clr", 32'(sig_lost), 32'(0));
        check("restart_period",  32'(last_p),   32'(10));
        check("restart_high",    32'(last_h),   32'(5));

        // Asynchronous reset in the middle of a high phase.
        sq(5, 5, 2);
        sig_in = 1'b1;
        #13 rst = 1'b1;
        sig_in = 1'b0;
        #1;
        check("arst_period", 32'(period_cycles), 32'(0));
        check("arst_high",   32'(high_cycles),   32'(0));
        check("arst_valid",  32'(meas_valid),    32'(0));
        check("arst_lost",   32'(sig_lost),      32'(0));
        check("arst_state",  32'(dut.state_q),   32'(IDLE));
        repeat (2) @(negedge clk_in);
        #3 rst = 1'b0;
        @(negedge clk_in);
        strobes = 0;
        sq(5, 5, 2);
        check("arst_no_spurious", 32'(strobes), 32'(0));
        sq(5, 5, 2);
        check("arst_recover_strobes", 32'(strobes), 32'(2));
        check("arst_recover_period",  32'(last_p),  32'(10));
        check("arst_recover_high",    32'(last_h),  32'(5));

        // Random sub-cycle phase on every edge of a nominal 7/6 wave.
        for (int p = 0; p < 30; p++) begin
            if (p == 2) jit_on = 1'b1;
            off_r = offs[$urandom_range(0, 7)];
            off_f = offs[$urandom_range(0, 7)];
            #(off_r) sig_in = 1'b1;
            #(70 - off_r + off_f) sig_in = 1'b0;
            #(60 - off_f);
        end
        repeat (2) @(negedge clk_in);
        jit_on = 1'b0;
        repeat (5) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
